// File: rtl/param_code_detonator.sv
// Parametrised code-entry detonator: N-digit code, retry lockout, runtime re-programming,
// pausable countdown. Optional entry/setup idle timeout when ENTRY_TIMEOUT_EN is defined.
module param_code_detonator #(
    parameter int                    CODE_LEN     = 4,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h2580,
    parameter int                    MAX_TRIES    = 3,
    parameter int                    FIRE_DELAY   = 5,
    parameter int                    ERR_CYC      = 2,
    parameter int                    LOCK_CYC     = 0
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int                    ENTRY_TO     = 64
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] A,
    input  logic       ready,
    input  logic       setup,
    input  logic       sure,
    input  logic       fire,
    input  logic       wait_t,
    output logic [3:0] m_disp,
    output logic       lt,
    output logic       bt,
    output logic       rt,
    output logic       lb
);

    localparam int BW = CODE_LEN * 4;

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_SET, S_ARMED, S_COUNT, S_BOOM, S_ERROR, S_LOCKED
    } state_t;

    function automatic logic is_onehot(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return (n == 4'd1);
    endfunction

    function automatic logic [3:0] onehot_idx(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) idx = 4'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    state_t        state_r, state_n;
    logic [BW-1:0] buf_r, buf_n, code_r, code_n;
    logic [3:0]    cnt_r, cnt_n, fail_r, fail_n;
    logic [15:0]   tmr_r, tmr_n;
    logic [9:0]    a_prev_r;
    logic [3:0]    disp_r, disp_n;
    logic          lt_r, lt_n, bt_r, bt_n, rt_r, rt_n, lb_r, lb_n;
    logic          key_ev_s, timeout_s, mism_s;
    logic [3:0]    digit_s, fail_inc_s;

    assign key_ev_s   = (a_prev_r == 10'd0) && is_onehot(A);
    assign digit_s    = onehot_idx(A);
    assign fail_inc_s = fail_r + 4'd1;
    assign mism_s     = timeout_s || (cnt_r != 4'(CODE_LEN)) || (buf_r != code_r);

`ifdef ENTRY_TIMEOUT_EN
    logic [15:0] idle_r;
    assign timeout_s = ((state_r == S_ENTRY) || (state_r == S_SET)) && !sure && !key_ev_s
                       && (idle_r == 16'(ENTRY_TO - 1));

    // idle cycles since the last key event while collecting digits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_r <= 16'd0;
        end else if (((state_r != S_ENTRY) && (state_r != S_SET)) || key_ev_s) begin
            idle_r <= 16'd0;
        end else begin
            idle_r <= idle_r + 16'd1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // next-state, datapath and next-output decode; outputs follow the next state
    always_comb begin
        state_n = state_r;
        buf_n   = buf_r;
        cnt_n   = cnt_r;
        code_n  = code_r;
        fail_n  = fail_r;
        tmr_n   = tmr_r;
        case (state_r)
            S_IDLE: begin
                if (ready)      state_n = S_ENTRY;
                else if (setup) state_n = S_SET;
                else            state_n = S_IDLE;
            end
            S_ENTRY, S_SET: begin
                if (sure || timeout_s) begin
                    if (state_r == S_ENTRY) begin
                        if (!mism_s) begin
                            fail_n  = 4'd0;
                            state_n = S_ARMED;
                        end else begin
                            fail_n = fail_inc_s;
                            if (fail_inc_s == 4'(MAX_TRIES)) begin
                                state_n = S_LOCKED;
                                tmr_n   = 16'(LOCK_CYC);
                            end else begin
                                state_n = S_ERROR;
                                tmr_n   = 16'(ERR_CYC);
                            end
                        end
                    end else begin
                        if (!timeout_s && (cnt_r == 4'(CODE_LEN))) begin
                            code_n  = buf_r;
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_ERROR;
                            tmr_n   = 16'(ERR_CYC);
                        end
                    end
                end else if (key_ev_s && (cnt_r < 4'(CODE_LEN))) begin
                    buf_n = (buf_r << 4) | BW'(digit_s);
                    cnt_n = cnt_r + 4'd1;
                end else begin
                    state_n = state_r;
                end
            end
            S_ARMED: begin
                if (fire) begin
                    tmr_n   = 16'(FIRE_DELAY);
                    state_n = S_COUNT;
                end else begin
                    state_n = S_ARMED;
                end
            end
            S_COUNT: begin
                if (wait_t) begin
                    tmr_n = tmr_r;
                end else if (tmr_r <= 16'd1) begin
                    tmr_n   = 16'd0;
                    state_n = S_BOOM;
                end else begin
                    tmr_n = tmr_r - 16'd1;
                end
            end
            S_BOOM: begin
                state_n = S_BOOM;
            end
            S_ERROR: begin
                if (tmr_r <= 16'd1) state_n = S_IDLE;
                else                tmr_n   = tmr_r - 16'd1;
            end
            S_LOCKED: begin
                // LOCK_CYC of zero holds the lockout until reset
                if (LOCK_CYC != 0) begin
                    if (tmr_r <= 16'd1) begin
                        fail_n  = 4'd0;
                        state_n = S_IDLE;
                    end else begin
                        tmr_n = tmr_r - 16'd1;
                    end
                end else begin
                    state_n = S_LOCKED;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if ((state_n == S_IDLE) && (state_r != S_IDLE)) begin
            buf_n = '0;
            cnt_n = 4'd0;
        end else begin
            cnt_n = cnt_n;
        end

        disp_n = 4'd0;
        lt_n   = 1'b0;
        bt_n   = 1'b0;
        rt_n   = 1'b0;
        lb_n   = 1'b0;
        case (state_n)
            S_ENTRY, S_SET: disp_n = buf_n[3:0];
            S_ARMED:        lt_n   = 1'b1;
            S_COUNT: begin
                lt_n   = 1'b1;
                disp_n = (tmr_n > 16'd9) ? 4'd9 : tmr_n[3:0];
            end
            S_BOOM:         bt_n   = 1'b1;
            S_ERROR: begin
                rt_n   = 1'b1;
                disp_n = fail_n;
            end
            S_LOCKED: begin
                lb_n   = 1'b1;
                disp_n = 4'hF;
            end
            default:        disp_n = 4'd0;
        endcase
    end

    // state, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            buf_r    <= '0;
            cnt_r    <= 4'd0;
            code_r   <= DEFAULT_CODE;
            fail_r   <= 4'd0;
            tmr_r    <= 16'd0;
            a_prev_r <= 10'd0;
            disp_r   <= 4'd0;
            lt_r     <= 1'b0;
            bt_r     <= 1'b0;
            rt_r     <= 1'b0;
            lb_r     <= 1'b0;
        end else begin
            state_r  <= state_n;
            buf_r    <= buf_n;
            cnt_r    <= cnt_n;
            code_r   <= code_n;
            fail_r   <= fail_n;
            tmr_r    <= tmr_n;
            a_prev_r <= A;
            disp_r   <= disp_n;
            lt_r     <= lt_n;
            bt_r     <= bt_n;
            rt_r     <= rt_n;
            lb_r     <= lb_n;
        end
    end

    assign m_disp = disp_r;
    assign lt     = lt_r;
    assign bt     = bt_r;
    assign rt     = rt_r;
    assign lb     = lb_r;

endmodule

// File: tb/tb_param_code_detonator.sv
// Directed bench for param_code_detonator (default parameters).
// Outputs are compared packed as {m_disp, lt, bt, rt, lb}.
module tb_param_code_detonator;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] A;
    logic       ready, setup, sure, fire, wait_t;
    logic [3:0] m_disp;
    logic       lt, bt, rt, lb;
    logic [7:0] outs;
    int         n_tests = 0;
    int         n_fail  = 0;

    assign outs = {m_disp, lt, bt, rt, lb};

    param_code_detonator dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .ready  (ready),
        .setup  (setup),
        .sure   (sure),
        .fire   (fire),
        .wait_t (wait_t),
        .m_disp (m_disp),
        .lt     (lt),
        .bt     (bt),
        .rt     (rt),
        .lb     (lb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        A = 10'd1 << d;
        tick();
        A = 10'd0;
        tick();
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) begin
            press(int'(code[i*4 +: 4]));
        end
    endtask

    task automatic pulse_ready();
        ready = 1'b1; tick(); ready = 1'b0;
    endtask

    task automatic pulse_setup();
        setup = 1'b1; tick(); setup = 1'b0;
    endtask

    task automatic pulse_sure();
        sure = 1'b1; tick(); sure = 1'b0;
    endtask

    task automatic pulse_fire();
        fire = 1'b1; tick(); fire = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        A = 10'd0; ready = 1'b0; setup = 1'b0; sure = 1'b0; fire = 1'b0; wait_t = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        A = 10'd0; ready = 1'b0; setup = 1'b0; sure = 1'b0; fire = 1'b0; wait_t = 1'b0;
        tick();
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_outs got=%h exp=00", outs); end
        rst = 1'b1;
        tick();
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL idle_after_reset got=%h exp=00", outs); end
    endtask

    task automatic test_correct();
        pulse_ready();
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL entry_start got=%h exp=00", outs); end
        press(2); press(5); press(8);
        n_tests++;
        if (outs !== 8'h80) begin n_fail++; $display("FAIL entry_last_digit got=%h exp=80", outs); end
        press(0);
        pulse_sure();
        n_tests++;
        if (outs !== 8'h08) begin n_fail++; $display("FAIL armed got=%h exp=08", outs); end
        pulse_fire();
        n_tests++;
        if (outs !== 8'h58) begin n_fail++; $display("FAIL count_start got=%h exp=58", outs); end
        for (int k = 4; k >= 1; k--) begin
            logic [7:0] exp_v;
            exp_v = {4'(k), 4'h8};
            tick();
            n_tests++;
            if (outs !== exp_v) begin n_fail++; $display("FAIL count_step got=%h exp=%h", outs, exp_v); end
        end
        tick();
        n_tests++;
        if (outs !== 8'h04) begin n_fail++; $display("FAIL boom got=%h exp=04", outs); end
        pulse_ready();
        tick();
        n_tests++;
        if (outs !== 8'h04) begin n_fail++; $display("FAIL boom_terminal got=%h exp=04", outs); end
    endtask

    task automatic test_wrong();
        pulse_ready();
        enter(16'h2581);
        pulse_sure();
        n_tests++;
        if (outs !== 8'h12) begin n_fail++; $display("FAIL wrong_err1 got=%h exp=12", outs); end
        tick();
        n_tests++;
        if (outs !== 8'h12) begin n_fail++; $display("FAIL wrong_err2 got=%h exp=12", outs); end
        tick();
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL wrong_idle got=%h exp=00", outs); end
    endtask

    // continues from test_wrong: one failure already counted
    task automatic test_reprogram();
        pulse_setup();
        press(1); press(2);
        n_tests++;
        if (outs !== 8'h20) begin n_fail++; $display("FAIL set_digit got=%h exp=20", outs); end
        pulse_sure();
        n_tests++;
        if (outs !== 8'h12) begin n_fail++; $display("FAIL set_short_err got=%h exp=12", outs); end
        tick(); tick();
        pulse_setup();
        enter(16'h1234);
        pulse_sure();
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL set_done got=%h exp=00", outs); end
        pulse_ready();
        enter(16'h2580);
        pulse_sure();
        n_tests++;
        if (outs !== 8'h22) begin n_fail++; $display("FAIL old_code_rejected got=%h exp=22", outs); end
        tick(); tick();
        pulse_ready();
        enter(16'h1234);
        pulse_sure();
        n_tests++;
        if (outs !== 8'h08) begin n_fail++; $display("FAIL new_code_armed got=%h exp=08", outs); end
        setup = 1'b1; sure = 1'b1; ready = 1'b1;
        tick();
        setup = 1'b0; sure = 1'b0; ready = 1'b0;
        n_tests++;
        if (outs !== 8'h08) begin n_fail++; $display("FAIL armed_ignores got=%h exp=08", outs); end
    endtask

    // continues from ARMED
    task automatic test_pause();
        pulse_fire();
        n_tests++;
        if (outs !== 8'h58) begin n_fail++; $display("FAIL pause_start got=%h exp=58", outs); end
        wait_t = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (outs !== 8'h58) begin n_fail++; $display("FAIL pause_hold got=%h exp=58", outs); end
        end
        wait_t = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            logic [7:0] exp_v;
            exp_v = {4'(k), 4'h8};
            tick();
            n_tests++;
            if (outs !== exp_v) begin n_fail++; $display("FAIL pause_step got=%h exp=%h", outs, exp_v); end
        end
        tick();
        n_tests++;
        if (outs !== 8'h04) begin n_fail++; $display("FAIL pause_boom got=%h exp=04", outs); end
    endtask

    task automatic test_key_edge();
        do_reset();
        pulse_ready();
        A = 10'b0000100100;
        tick();
        A = 10'd0;
        tick();
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL multi_hot got=%h exp=00", outs); end
        A = 10'd1 << 2;
        tick(); tick(); tick();
        n_tests++;
        if (outs !== 8'h20) begin n_fail++; $display("FAIL held_key got=%h exp=20", outs); end
        A = 10'd0;
        tick();
        press(5); press(8); press(0);
        press(9);
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL fifth_ignored got=%h exp=00", outs); end
        pulse_sure();
        n_tests++;
        if (outs !== 8'h08) begin n_fail++; $display("FAIL five_digits_armed got=%h exp=08", outs); end
    endtask

    task automatic test_lockout();
        do_reset();
        for (int a = 1; a <= 3; a++) begin
            logic [7:0] exp_v;
            exp_v = (a < 3) ? {4'(a), 4'h2} : 8'hF1;
            pulse_ready();
            enter(16'h2581);
            pulse_sure();
            n_tests++;
            if (outs !== exp_v) begin n_fail++; $display("FAIL lock_attempt got=%h exp=%h", outs, exp_v); end
            tick(); tick();
        end
        pulse_ready();
        enter(16'h2580);
        pulse_sure();
        n_tests++;
        if (outs !== 8'hF1) begin n_fail++; $display("FAIL locked_hold got=%h exp=F1", outs); end
        do_reset();
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL lock_cleared got=%h exp=00", outs); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_setup();
        enter(16'h1234);
        pulse_sure();
        pulse_ready();
        enter(16'h1234);
        pulse_sure();
        pulse_fire();
        tick(); tick(); tick();
        n_tests++;
        if (outs !== 8'h28) begin n_fail++; $display("FAIL count_at_2 got=%h exp=28", outs); end
        rst = 1'b0;
        #2;
        n_tests++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL async_reset got=%h exp=00", outs); end
        tick();
        rst = 1'b1;
        pulse_ready();
        enter(16'h2580);
        pulse_sure();
        n_tests++;
        if (outs !== 8'h08) begin n_fail++; $display("FAIL default_restored got=%h exp=08", outs); end
    endtask

    initial begin
        test_reset();
        test_correct();
        do_reset();
        test_wrong();
        test_reprogram();
        test_pause();
        test_key_edge();
        test_lockout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_code_detonator.md
Name: param_code_detonator

Overview:
Parametrised successor to the fixed 4-digit code detonator. It has a configurable code length and a retry limit with lockout. The stored code can be re-programmed at runtime. Firing uses a pausable countdown.
- Sits between the 10-key one-hot keypad / control buttons and the display and lamp drivers.
- All inputs are synchronous to clk. Debouncing is handled upstream.

Parameters:
- CODE_LEN, 4: number of digits in the code (1..8).
- DEFAULT_CODE, 16'h2580: reset value of the stored code, 4 bits per digit, first digit in the MS nibble. Width is CODE_LEN*4.
- MAX_TRIES, 3: consecutive failed verifications before lockout (1..15).
- FIRE_DELAY, 5: countdown length in cycles from fire to detonation (>=1).
- ERR_CYC, 2: cycles spent in ERROR with rt lit (>=1).
- LOCK_CYC, 0: cycles spent in LOCKED before returning to IDLE; 0 means locked until reset.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- A, in, 10: keypad, one-hot; bit k means digit k.
- ready, in, 1: start a code-entry attempt (level, sampled).
- setup, in, 1: start code re-programming.
- sure, in, 1: confirm the entered digits.
- fire, in, 1: start the countdown when armed.
- wait_t, in, 1: freeze the countdown while high.
- m_disp, out, 4: display digit.
- lt, out, 1: armed / ready lamp.
- bt, out, 1: detonate output.
- rt, out, 1: error lamp.
- lb, out, 1: lockout lamp.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; stored code = DEFAULT_CODE; fail_cnt=0; digit buffer and count = 0.
  - All outputs 0 (m_disp=0, lt=bt=rt=lb=0).
- Key capture:
  - Registered A_prev. A key event fires when A_prev==0 and A is exactly one-hot. The digit is the index of the set bit.
  - Multi-hot or held keys produce no event.
  - Each event shifts the digit into the buffer (LS nibble) and increments count, saturating at CODE_LEN.
  - Digits after count==CODE_LEN are ignored.
- All outputs are registered: they change one cycle after the triggering input edge is sampled.
- States:
  - IDLE
    - ready -> ENTRY; setup -> SET. If both are high, ready wins.
    - On entry to IDLE, the buffer and count are cleared.
    - m_disp=0.
  - ENTRY / SET
    - m_disp = last captured digit (0 if none).
    - sure has priority over a key event in the same cycle; that key is discarded.
  - ENTRY + sure
    - If count==CODE_LEN and buffer==stored: fail_cnt=0, go to ARMED.
    - Otherwise fail_cnt+1. If the new fail_cnt==MAX_TRIES, go to LOCKED; else go to ERROR.
  - SET + sure
    - If count==CODE_LEN: stored=buffer, go to IDLE.
    - Otherwise go to ERROR with fail_cnt unchanged. The stored code is not modified.
  - ARMED
    - lt=1, m_disp=0.
    - fire loads the counter with FIRE_DELAY and goes to COUNT.
    - ready, setup and sure are ignored.
  - COUNT
    - lt=1.
    - Counter decrements each cycle with wait_t=0 and holds while wait_t=1.
    - m_disp = min(counter, 9).
    - When the counter reaches 0, go to BOOM.
  - BOOM
    - bt=1, lt=0, m_disp=0.
    - Terminal: only reset leaves it.
  - ERROR
    - rt=1, m_disp=fail_cnt.
    - After ERR_CYC cycles, go to IDLE.
  - LOCKED
    - lb=1, m_disp=4'hF.
    - All inputs are ignored.
    - If LOCK_CYC>0: after LOCK_CYC cycles, fail_cnt=0 and go to IDLE. If LOCK_CYC==0: stays until reset.
- Ignored inputs: ready and setup outside IDLE; fire outside ARMED; wait_t outside COUNT.
- Reset mid-operation: immediate return to the reset state, including restoring the stored code to DEFAULT_CODE.

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- With the macro defined:
  - Parameter ENTRY_TO (default 64) is added.
  - In ENTRY or SET, an idle counter clears on every key event and increments otherwise.
  - When it reaches ENTRY_TO, the attempt is treated as sure with a mismatch: same fail_cnt, LOCKED and ERROR rules as above.
  - In SET, a timeout goes to ERROR with no fail_cnt change.
- Without the macro: no timeout; ENTRY and SET wait indefinitely.

Test Plan:
Defaults, plus FIRE_DELAY=5, ERR_CYC=2.
- Correct code and countdown: ready; keys 2,5,8,0; sure -> lt=1 next cycle; fire -> m_disp 5,4,3,2,1, then bt=1 after 5 cycles; lt=0.
- Wrong code: ready; keys 2,5,8,1; sure -> rt=1 for 2 cycles, m_disp=1, then IDLE with all lamps 0.
- Lockout: 3 consecutive wrong attempts -> lb=1, m_disp=F; further ready/keys/sure produce no change until rst=0.
- Re-program: setup; keys 1,2,3,4; sure; then ready; 2,5,8,0; sure -> rt=1. Next attempt ready; 1,2,3,4; sure -> lt=1.
- Pause and key edge cases: A=0b0000100100 (multi-hot) or a held key produces no digit. Entering 5 digits leaves the first 4 stored. During COUNT, wait_t high for 3 cycles delays bt by exactly 3 cycles.
- Reset mid-COUNT: rst=0 at counter=2 -> all outputs 0 immediately; stored code returns to 2580.
